// File: rtl/psec5_spi_host.sv
// Host-side transaction sequencer for the PSEC5 SPI register block: address byte, data burst, then the 8-pulse iclk reset.
// Optional command address range check is enabled by defining PSEC5_ADDR_CHECK_EN.
module psec5_spi_host #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic [6:0] cmd_len,
  input  logic       cmd_write,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sclk,
  output logic       iclk,
  output logic       serial_in,
  input  logic       serial_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  // Handshakes: cmd and tx transfer on a rising edge where valid & ready are both high;
  // rx_valid is a one-cycle strobe with no backpressure.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_IRST  = 3'd4;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             phase_q, phase_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             wr_q, wr_d;
  logic             sclk_q, sclk_d;
  logic             iclk_q, iclk_d;
  logic             sin_q, sin_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             phase_end;
  logic             cmd_bad;
  logic [7:0]       shift_next;

`ifdef PSEC5_ADDR_CHECK_EN
  logic [8:0] addr_end;
  // Last addressed register is addr+len-1; compare addr+len against 66 to avoid the subtract.
  assign addr_end = {1'b0, cmd_addr} + {2'b00, cmd_len};
  assign cmd_bad  = (cmd_addr == 8'd0) || (cmd_addr > 8'd65) ||
                    ((cmd_len != 7'd0) && (addr_end > 9'd66));
`else
  assign cmd_bad = 1'b0;
`endif

  assign phase_end  = (div_cnt_q == DIV_LAST);
  assign shift_next = {shift_q[6:0], serial_out};

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    wr_d       = wr_q;
    sclk_d     = sclk_q;
    iclk_d     = iclk_q;
    sin_d      = sin_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d    = S_ADDR;
            shift_d    = cmd_addr;
            sin_d      = cmd_addr[7];
            byte_cnt_d = cmd_len;
            wr_d       = cmd_write;
            div_cnt_d  = '0;
            phase_d    = 1'b0;
            bit_cnt_d  = 3'd0;
            sclk_d     = 1'b0;
            iclk_d     = 1'b0;
          end
        end
      end

      S_ADDR, S_SHIFT: begin
        if (!phase_end) begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end else if (!phase_q) begin
          div_cnt_d = '0;
          phase_d   = 1'b1;
          sclk_d    = 1'b1;
        end else begin
          div_cnt_d = '0;
          phase_d   = 1'b0;
          sclk_d    = 1'b0;
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if ((state_q == S_SHIFT) && !wr_q) begin
              rx_data_d  = shift_next;
              rx_valid_d = 1'b1;
            end
            if (byte_cnt_q != 7'd0) begin
              // serial_in keeps the last data bit while waiting in LOAD.
              state_d = S_LOAD;
            end else begin
              state_d = S_IRST;
              sin_d   = 1'b0;
              iclk_d  = 1'b1;
              phase_d = 1'b1;
            end
          end else begin
            sin_d = shift_q[6];
          end
        end
      end

      S_LOAD: begin
        if (!wr_q || tx_valid) begin
          state_d    = S_SHIFT;
          shift_d    = wr_q ? tx_data : 8'h00;
          sin_d      = wr_q ? tx_data[7] : 1'b0;
          byte_cnt_d = byte_cnt_q - 7'd1;
          div_cnt_d  = '0;
          phase_d    = 1'b0;
          bit_cnt_d  = 3'd0;
        end
      end

      S_IRST: begin
        if (!phase_end) begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end else if (phase_q) begin
          div_cnt_d = '0;
          phase_d   = 1'b0;
          iclk_d    = 1'b0;
        end else begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            phase_d = 1'b1;
            iclk_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        iclk_d  = 1'b0;
        sin_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      phase_q    <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 7'd0;
      shift_q    <= 8'h00;
      wr_q       <= 1'b0;
      sclk_q     <= 1'b0;
      iclk_q     <= 1'b0;
      sin_q      <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      wr_q       <= wr_d;
      sclk_q     <= sclk_d;
      iclk_q     <= iclk_d;
      sin_q      <= sin_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign tx_ready  = (state_q == S_LOAD) && wr_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign sclk      = sclk_q;
  assign iclk      = iclk_q;
  assign serial_in = sin_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
